// File: rtl/parity_check_8bit_tester.sv
// Odd-parity of an 8-bit word via a golden XOR reduction and an explicit XOR tree, both registered with one-cycle latency.
// Optional build macro PARITY_CHECK_CNT_EN adds a saturating mismatch counter (err_cnt) and a sticky error flag (err_sticky).
module parity_check_8bit_tester #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] din,
  output logic              dout_odd_true,
  output logic              dout_odd_test,
  output logic              mismatch
`ifdef PARITY_CHECK_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
`endif
);

  if (DATA_W != 8 || CNT_W < 1) begin : g_param_check
    $error("parity_check_8bit_tester supports DATA_W == 8 and CNT_W >= 1 only");
  end

  logic       w_par_true;
  logic [3:0] w_s1;
  logic [1:0] w_s2;
  logic       w_par_test;
  logic       r_odd_true_p1;
  logic       r_odd_test_p1;
  logic       w_mismatch;

  // stage p0: combinational parity, golden reduction and explicit tree
  assign w_par_true = ^din;

  assign w_s1[0] = din[0] ^ din[1];
  assign w_s1[1] = din[2] ^ din[3];
  assign w_s1[2] = din[4] ^ din[5];
  assign w_s1[3] = din[6] ^ din[7];
  assign w_s2[0] = w_s1[0] ^ w_s1[1];
  assign w_s2[1] = w_s1[2] ^ w_s1[3];
  assign w_par_test = w_s2[0] ^ w_s2[1];

  // stage p1: both results registered on the same edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_odd_true_p1 <= 1'b0;
      r_odd_test_p1 <= 1'b0;
    end else begin
      r_odd_true_p1 <= w_par_true;
      r_odd_test_p1 <= w_par_test;
    end
  end

  assign w_mismatch    = r_odd_true_p1 ^ r_odd_test_p1;
  assign dout_odd_true = r_odd_true_p1;
  assign dout_odd_test = r_odd_test_p1;
  assign mismatch      = w_mismatch;

`ifdef PARITY_CHECK_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_sticky;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_mismatch) begin
      r_err_cnt    <= sat_inc(r_err_cnt);
      r_err_sticky <= 1'b1;
    end
  end

  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_parity_check_8bit_tester.sv
// Directed and random bench for parity_check_8bit_tester; counter checks are built when PARITY_CHECK_CNT_EN is defined.
module tb_parity_check_8bit_tester;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  din;
  logic        dout_odd_true;
  logic        dout_odd_test;
  logic        mismatch;
`ifdef PARITY_CHECK_CNT_EN
  logic [15:0] err_cnt;
  logic        err_sticky;
`endif

  int total = 0;
  int fails = 0;

  parity_check_8bit_tester #(.DATA_W(8), .CNT_W(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .din          (din),
    .dout_odd_true(dout_odd_true),
    .dout_odd_test(dout_odd_test),
    .mismatch     (mismatch)
`ifdef PARITY_CHECK_CNT_EN
    ,
    .err_cnt      (err_cnt),
    .err_sticky   (err_sticky)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: odd parity is simply "count of ones is odd".
  function automatic logic ref_par(input logic [7:0] d);
    return (($countones(d) % 2) == 1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive d at a falling edge, let one rising edge capture it, then check at the next falling edge.
  task automatic step(input logic [7:0] d, input string tag);
    din = d;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk({tag, "_true"}, {15'd0, dout_odd_true}, {15'd0, ref_par(d)});
    chk({tag, "_test"}, {15'd0, dout_odd_test}, {15'd0, ref_par(d)});
    chk({tag, "_mm"},   {15'd0, mismatch},      16'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic       held;

    // Reset held low with an all-ones word present
    sys_rst_n = 1'b0;
    din       = 8'hFF;
    #1;
    chk("rst_true", {15'd0, dout_odd_true}, 16'd0);
    chk("rst_test", {15'd0, dout_odd_test}, 16'd0);
    chk("rst_mm",   {15'd0, mismatch},      16'd0);
`ifdef PARITY_CHECK_CNT_EN
    chk("rst_cnt",    err_cnt,                 16'd0);
    chk("rst_sticky", {15'd0, err_sticky},     16'd0);
`endif
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_edge_true", {15'd0, dout_odd_true}, 16'd0);
    sys_rst_n = 1'b1;
    step(8'hFF, "ff");

    step(8'h00, "h00");
    step(8'h01, "h01");
    step(8'h80, "h80");
    step(8'hB5, "hB5");
    step(8'h3C, "h3C");

    // A change between edges must not reach the outputs
    held = dout_odd_true;
    din  = 8'h01;
    #2;
    chk("between_edges", {15'd0, dout_odd_true}, {15'd0, held});

    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom);
      step(r, "rnd");
    end
`ifdef PARITY_CHECK_CNT_EN
    chk("rnd_cnt",    err_cnt,             16'd0);
    chk("rnd_sticky", {15'd0, err_sticky}, 16'd0);
`endif

    // Invert the test path for three captures
    step(8'h01, "pre_force");
    force dut.w_par_test = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("force_mm",   {15'd0, mismatch},      16'd1);
      chk("force_test", {15'd0, dout_odd_test}, 16'd0);
    end
    release dut.w_par_test;
    step(8'h01, "post_force");
`ifdef PARITY_CHECK_CNT_EN
    chk("force_cnt",    err_cnt,             16'd3);
    chk("force_sticky", {15'd0, err_sticky}, 16'd1);
`endif

    // Asynchronous reset pulse clears everything at once
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_true", {15'd0, dout_odd_true}, 16'd0);
    chk("midrst_mm",   {15'd0, mismatch},      16'd0);
`ifdef PARITY_CHECK_CNT_EN
    chk("midrst_cnt",    err_cnt,             16'd0);
    chk("midrst_sticky", {15'd0, err_sticky}, 16'd0);
`endif
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(8'h07, "after_rst");

`ifdef PARITY_CHECK_CNT_EN
    // Saturation: preload near full scale, then three more mismatches
    force dut.r_err_cnt = 16'hFFFE;
    #1;
    release dut.r_err_cnt;
    chk("preload", err_cnt, 16'hFFFE);
    force dut.w_par_test = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    release dut.w_par_test;
    step(8'h07, "post_sat");
    chk("sat_cnt",    err_cnt,             16'hFFFF);
    chk("sat_sticky", {15'd0, err_sticky}, 16'd1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
